shadow_store_buffer: RTL and testbench
======================================

Name: shadow_store_buffer

Overview:
- Small in-order store FIFO between the shadow register controller and the data-cache store port.
- Accepts (address, data, last) beats from the controller at full rate and decouples it from cache grant latency.
- Drains entries to the cache with a req/gnt handshake and signals when a whole shadow frame has been written.
- Flags loads whose page offset aliases a pending shadow store, so the load unit stalls.

Parameters:
- DATA_WIDTH, 64, width of store address and data; must be 32 or 64.
- DEPTH, 4, number of buffer entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- push_valid_i  in  1  controller presents a store beat
- push_ready_o  out  1  buffer can accept a beat
- push_addr_i  in  DATA_WIDTH  store byte address, word-aligned
- push_data_i  in  DATA_WIDTH  store data
- push_last_i  in  1  beat is the final store of a shadow frame
- mem_req_o  out  1  store request to cache
- mem_gnt_i  in  1  cache accepts the request
- mem_addr_o  out  DATA_WIDTH  head entry address
- mem_wdata_o  out  DATA_WIDTH  head entry data
- mem_be_o  out  DATA_WIDTH/8  byte enables
- mem_we_o  out  1  write strobe
- frame_done_o  out  1  one-cycle pulse: last beat of a frame granted
- page_offset_i  in  12  page offset of the load being issued
- page_offset_match_o  out  1  load offset aliases a pending or incoming entry
- empty_o  out  1  no entries held
- count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset values:
  - count_o=0, empty_o=1, push_ready_o=1.
  - mem_req_o=0, mem_we_o=0, frame_done_o=0, page_offset_match_o=0.
  - Read/write pointers=0; all entry valid bits cleared.
- Reset mid-operation discards all entries. No grant is expected afterwards.
- Storage: circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. Each entry holds addr, data and last.
- Push:
  - Accepted when push_valid_i && push_ready_o.
  - push_ready_o = (count < DEPTH), purely from registered state.
  - When full, push_ready_o=0 even if a pop occurs the same cycle; there is no full-bypass.
- Drain:
  - mem_req_o = !empty. mem_we_o = mem_req_o. mem_be_o = all ones whenever mem_req_o=1, else 0.
  - mem_addr_o and mem_wdata_o show the head entry. They must stay stable while mem_req_o && !mem_gnt_i.
  - Pop on mem_req_o && mem_gnt_i.
  - No fall-through: a beat pushed in cycle N first appears at the head in cycle N+1 at the earliest. Minimum push-to-request latency is 1 cycle.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance. Push into an empty buffer plus a grant the same cycle cannot occur, because mem_req_o=0 when empty.
- Counting: count increments on push only, decrements on pop only, and is unchanged on both or neither. It never exceeds DEPTH or goes below 0. empty_o = (count==0).
- frame_done_o: registered. Asserted exactly one cycle after the cycle in which the popped head entry has last=1. Otherwise 0.
- Page-offset match (combinational):
  - ALIGN = $clog2(DATA_WIDTH/8).
  - page_offset_match_o=1 if page_offset_i[11:ALIGN] equals addr[11:ALIGN] of any valid entry.
  - It also matches the beat being accepted this cycle (push_valid_i && push_ready_o).
  - An entry being popped this cycle still counts as matching.
- Ordering: strict FIFO; entries are never reordered or merged.
- Assertions for the bench:
  - No push while !push_ready_o is accepted.
  - mem_addr_o and mem_wdata_o are stable under req without gnt.
  - count_o <= DEPTH.
  - push_addr_i[ALIGN-1:0]==0 on every accepted push.

Test Plan:
- Reset then idle, DEPTH=4, DATA_WIDTH=64 -> count_o=0, empty_o=1, mem_req_o=0, push_ready_o=1, mem_be_o=0x00.
- Push one beat (addr 0x8000_1F08, data 0xDEAD, last=1) with mem_gnt_i=1 tied high -> mem_req_o high in cycle N+1 with addr 0x8000_1F08 and mem_be_o=0xFF; pop in N+1; frame_done_o pulses in N+2; empty_o=1 in N+2.
- Push 4 beats back-to-back with mem_gnt_i=0 -> push_ready_o=0 after the 4th; a 5th push is held; mem_addr_o stays at the first address for 10 stall cycles; then gnt each cycle -> 4 stores in push order and frame_done_o only after the beat tagged last.
- Full buffer, push_valid_i=1 and mem_gnt_i=1 in the same cycle -> pop occurs, push is refused that cycle, count goes 4->3, and the push is accepted the next cycle (count 3->3 with a simultaneous pop).
- Pending entry addr 0x...0F10, page_offset_i=0xF10 -> match=1. page_offset_i=0xF14 -> match=1 (same 8-byte word). page_offset_i=0xF18 -> match=0. Same-cycle accepted push of addr 0x...0A00 with page_offset_i=0xA00 -> match=1.
- Pointer wrap: stream 11 beats with random gnt gaps -> all 11 appear in order with no loss or duplication. Assert rst_ni low with 3 entries held -> mem_req_o=0 immediately, and count_o=0 after release.

Source files
------------

// File: rtl/shadow_store_buffer.sv
// shadow_store_buffer: in-order store FIFO between the shadow register
// controller and the data-cache store port.
//   push_*   : store beats (addr, data, last) from the controller, valid/ready
//   mem_*    : head entry presented to the cache, popped on req && gnt
//   frame_done_o        : one-cycle pulse after the last beat of a frame pops
//   page_offset_i/_match_o : load alias detection against held/incoming stores
//   empty_o, count_o    : occupancy status
module shadow_store_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_valid_i,
  output logic                          push_ready_o,
  input  logic [DATA_WIDTH-1:0]         push_addr_i,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  input  logic                          push_last_i,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [DATA_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]       mem_be_o,
  output logic                          mem_we_o,
  output logic                          frame_done_o,
  input  logic [11:0]                   page_offset_i,
  output logic                          page_offset_match_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned BW    = DATA_WIDTH / 8;
  localparam int unsigned ALIGN = $clog2(BW);

  // Elaboration-time parameter sanity
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("shadow_store_buffer: DATA_WIDTH must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("shadow_store_buffer: DEPTH must be a power of two >= 2");
  end

  logic [DATA_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      last_q;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  frame_done_q, frame_done_d;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  match;
  logic                  page_lsb_unused;

  // Status derived purely from registered occupancy
  assign push_ready_o = (count_q < CW'(DEPTH));
  assign mem_req_o    = (count_q != '0);
  assign mem_we_o     = mem_req_o;
  assign mem_be_o     = {BW{mem_req_o}};
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign frame_done_o = frame_done_q;

  // Head entry; held stable under stall because rptr only moves on a pop
  assign mem_addr_o  = addr_q[rptr_q];
  assign mem_wdata_o = data_q[rptr_q];

  assign push_fire = push_valid_i && push_ready_o;
  assign pop_fire  = mem_req_o && mem_gnt_i;

  // Next-state for pointers, occupancy, valid bits and frame-done pulse
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    if (push_fire) begin
      wptr_d          = wptr_q + PW'(1);
      valid_d[wptr_q] = 1'b1;
    end
    if (pop_fire) begin
      rptr_d          = rptr_q + PW'(1);
      valid_d[rptr_q] = 1'b0;
      frame_done_d    = last_q[rptr_q];
    end
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Payload storage; contents are only meaningful where valid_q is set
  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      addr_q[wptr_q] <= push_addr_i;
      data_q[wptr_q] <= push_data_i;
      last_q[wptr_q] <= push_last_i;
    end
  end

  // Load alias check at word granularity; an entry popping this cycle still counts
  always_comb begin
    match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][11:ALIGN] == page_offset_i[11:ALIGN])) begin
        match = 1'b1;
      end
    end
    if (push_fire && (push_addr_i[11:ALIGN] == page_offset_i[11:ALIGN])) begin
      match = 1'b1;
    end
  end
  assign page_offset_match_o = match;

  // Sub-word offset bits do not participate in aliasing
  assign page_lsb_unused = ^page_offset_i[ALIGN-1:0];

endmodule

// File: tb/tb_shadow_store_buffer.sv
module tb_shadow_store_buffer;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          push_valid_i = 1'b0;
  logic          push_ready_o;
  logic [DW-1:0] push_addr_i = '0;
  logic [DW-1:0] push_data_i = '0;
  logic          push_last_i = 1'b0;
  logic          mem_req_o;
  logic          mem_gnt_i = 1'b0;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic          mem_we_o;
  logic          frame_done_o;
  logic [11:0]   page_offset_i = '0;
  logic          page_offset_match_o;
  logic          empty_o;
  logic [CW-1:0] count_o;

  int checks = 0;
  int errors = 0;

  shadow_store_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .push_valid_i        (push_valid_i),
    .push_ready_o        (push_ready_o),
    .push_addr_i         (push_addr_i),
    .push_data_i         (push_data_i),
    .push_last_i         (push_last_i),
    .mem_req_o           (mem_req_o),
    .mem_gnt_i           (mem_gnt_i),
    .mem_addr_o          (mem_addr_o),
    .mem_wdata_o         (mem_wdata_o),
    .mem_be_o            (mem_be_o),
    .mem_we_o            (mem_we_o),
    .frame_done_o        (frame_done_o),
    .page_offset_i       (page_offset_i),
    .page_offset_match_o (page_offset_match_o),
    .empty_o             (empty_o),
    .count_o             (count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference model: a plain queue of beats in arrival order
  typedef struct {
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t m_q[$];
  logic  m_fd = 1'b0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q.delete();
      m_fd = 1'b0;
    end else begin
      automatic bit    pop  = (m_q.size() > 0) && mem_gnt_i;
      automatic bit    push = push_valid_i && (m_q.size() < DEPTH);
      automatic beat_t b;
      m_fd = pop && m_q[0].last;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        b.addr = push_addr_i;
        b.data = push_data_i;
        b.last = push_last_i;
        m_q.push_back(b);
      end
    end
  end

  // Every-cycle scoreboard and protocol assertions, sampled mid-cycle
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_addr, prev_data;

  always @(negedge clk_i) begin
    automatic int sz = m_q.size();
    automatic bit exp_match = 1'b0;
    foreach (m_q[i]) if (m_q[i].addr[11:3] == page_offset_i[11:3]) exp_match = 1'b1;
    if (push_valid_i && sz < DEPTH && push_addr_i[11:3] == page_offset_i[11:3]) exp_match = 1'b1;

    checks++;
    if (count_o !== CW'(sz)) begin
      errors++; $display("FAIL mon_count: got %0d expected %0d at %0t", count_o, sz, $time);
    end
    checks++;
    if (empty_o !== (sz == 0) || mem_req_o !== (sz != 0) || mem_we_o !== (sz != 0)) begin
      errors++; $display("FAIL mon_status: empty=%0b req=%0b we=%0b expected occupancy %0d at %0t",
                         empty_o, mem_req_o, mem_we_o, sz, $time);
    end
    checks++;
    if (push_ready_o !== (sz < DEPTH)) begin
      errors++; $display("FAIL mon_ready: got %0b expected %0b at %0t", push_ready_o, sz < DEPTH, $time);
    end
    checks++;
    if (mem_be_o !== ((sz != 0) ? {BW{1'b1}} : {BW{1'b0}})) begin
      errors++; $display("FAIL mon_be: got %h for occupancy %0d at %0t", mem_be_o, sz, $time);
    end
    if (sz != 0) begin
      checks++;
      if (mem_addr_o !== m_q[0].addr || mem_wdata_o !== m_q[0].data) begin
        errors++; $display("FAIL mon_head: got %h/%h expected %h/%h at %0t",
                           mem_addr_o, mem_wdata_o, m_q[0].addr, m_q[0].data, $time);
      end
    end
    checks++;
    if (frame_done_o !== m_fd) begin
      errors++; $display("FAIL mon_frame_done: got %0b expected %0b at %0t", frame_done_o, m_fd, $time);
    end
    checks++;
    if (page_offset_match_o !== exp_match) begin
      errors++; $display("FAIL mon_match: got %0b expected %0b offset %h at %0t",
                         page_offset_match_o, exp_match, page_offset_i, $time);
    end
    checks++;
    if (count_o > CW'(DEPTH)) begin
      errors++; $display("FAIL assert_count_bound: count %0d at %0t", count_o, $time);
    end
    if (stall_prev && mem_req_o) begin
      checks++;
      if (mem_addr_o !== prev_addr || mem_wdata_o !== prev_data) begin
        errors++; $display("FAIL assert_stable: got %h/%h held %h/%h at %0t",
                           mem_addr_o, mem_wdata_o, prev_addr, prev_data, $time);
      end
    end
    if (push_valid_i && push_ready_o) begin
      checks++;
      if (push_addr_i[2:0] !== 3'b000) begin
        errors++; $display("FAIL assert_align: push addr %h at %0t", push_addr_i, $time);
      end
    end
    stall_prev = rst_ni && mem_req_o && !mem_gnt_i;
    prev_addr  = mem_addr_o;
    prev_data  = mem_wdata_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] d,
                            input logic l);
    push_valid_i = v;
    push_addr_i  = a;
    push_data_i  = d;
    push_last_i  = l;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive_push(1'b0, '0, '0, 1'b0);
    mem_gnt_i = 1'b0;
    #12;
    checks++;
    if (count_o !== '0 || empty_o !== 1'b1 || mem_req_o !== 1'b0 || push_ready_o !== 1'b1 ||
        mem_be_o !== 8'h00 || mem_we_o !== 1'b0 || frame_done_o !== 1'b0 ||
        page_offset_match_o !== 1'b0) begin
      errors++; $display("FAIL reset_values: count=%0d empty=%0b req=%0b ready=%0b be=%h fd=%0b",
                         count_o, empty_o, mem_req_o, push_ready_o, mem_be_o, frame_done_o);
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single();
    mem_gnt_i = 1'b1;
    drive_push(1'b1, 64'h8000_1F08, 64'hDEAD, 1'b1);
    #1;
    checks++;
    if (mem_req_o !== 1'b0) begin
      errors++; $display("FAIL single_no_fallthrough: req got %0b expected 0", mem_req_o);
    end
    tick();
    drive_push(1'b0, '0, '0, 1'b0);
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000_1F08 || mem_be_o !== 8'hFF) begin
      errors++; $display("FAIL single_req: req=%0b addr=%h be=%h expected 1/80001f08/ff",
                         mem_req_o, mem_addr_o, mem_be_o);
    end
    tick();
    checks++;
    if (frame_done_o !== 1'b1 || empty_o !== 1'b1) begin
      errors++; $display("FAIL single_done: fd=%0b empty=%0b expected 1/1", frame_done_o, empty_o);
    end
    tick();
    checks++;
    if (frame_done_o !== 1'b0) begin
      errors++; $display("FAIL single_pulse_width: fd got %0b expected 0", frame_done_o);
    end
    mem_gnt_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a[4];
    logic [DW-1:0] d[4];
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a[i] = 64'h4000_0100 + 64'(i * 8);
      d[i] = {$urandom, $urandom};
      drive_push(1'b1, a[i], d[i], i == 1);
      tick();
    end
    checks++;
    if (push_ready_o !== 1'b0 || count_o !== CW'(4)) begin
      errors++; $display("FAIL b2b_full: ready=%0b count=%0d expected 0/4", push_ready_o, count_o);
    end
    drive_push(1'b1, 64'h4000_0200, 64'h5555, 1'b0);
    for (int s = 0; s < 10; s++) begin
      checks++;
      if (mem_addr_o !== a[0] || count_o !== CW'(4) || push_ready_o !== 1'b0) begin
        errors++; $display("FAIL b2b_stall: cycle %0d addr=%h count=%0d ready=%0b", s, mem_addr_o,
                           count_o, push_ready_o);
      end
      tick();
    end
    drive_push(1'b0, '0, '0, 1'b0);
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_addr_o !== a[i] || mem_wdata_o !== d[i] || frame_done_o !== (i == 2)) begin
        errors++; $display("FAIL b2b_drain: beat %0d addr=%h data=%h fd=%0b expected %h/%h/%0b", i,
                           mem_addr_o, mem_wdata_o, frame_done_o, a[i], d[i], i == 2);
      end
      tick();
    end
    checks++;
    if (frame_done_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++; $display("FAIL b2b_end: fd=%0b empty=%0b expected 0/1", frame_done_o, empty_o);
    end
    mem_gnt_i = 1'b0;
  endtask

  task automatic test_full_simul();
    logic [DW-1:0] last_popped = '0;
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 64'h2000_0000 + 64'(i * 16), 64'(i), 1'b0);
      tick();
    end
    drive_push(1'b1, 64'h2000_0E00, 64'hE, 1'b1);
    mem_gnt_i = 1'b1;
    #1;
    checks++;
    if (push_ready_o !== 1'b0 || count_o !== CW'(4)) begin
      errors++; $display("FAIL full_refuse: ready=%0b count=%0d expected 0/4", push_ready_o, count_o);
    end
    tick();
    checks++;
    if (count_o !== CW'(3) || push_ready_o !== 1'b1) begin
      errors++; $display("FAIL full_pop: count=%0d ready=%0b expected 3/1", count_o, push_ready_o);
    end
    tick();
    checks++;
    if (count_o !== CW'(3)) begin
      errors++; $display("FAIL full_simul: count got %0d expected 3", count_o);
    end
    drive_push(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 10 && count_o != '0; k++) begin
      if (mem_req_o && mem_gnt_i) last_popped = mem_addr_o;
      tick();
    end
    checks++;
    if (empty_o !== 1'b1 || last_popped !== 64'h2000_0E00) begin
      errors++; $display("FAIL full_order: empty=%0b last popped %h expected 20000e00", empty_o,
                         last_popped);
    end
    mem_gnt_i = 1'b0;
    tick();
  endtask

  task automatic test_match();
    mem_gnt_i = 1'b0;
    drive_push(1'b1, 64'h1234_0000_0000_0F10, 64'h1, 1'b0);
    page_offset_i = 12'h000;
    tick();
    drive_push(1'b0, '0, '0, 1'b0);
    page_offset_i = 12'hF10;
    #1;
    checks++;
    if (page_offset_match_o !== 1'b1) begin
      errors++; $display("FAIL match_exact: got %0b expected 1", page_offset_match_o);
    end
    page_offset_i = 12'hF14;
    #1;
    checks++;
    if (page_offset_match_o !== 1'b1) begin
      errors++; $display("FAIL match_same_word: got %0b expected 1", page_offset_match_o);
    end
    page_offset_i = 12'hF18;
    #1;
    checks++;
    if (page_offset_match_o !== 1'b0) begin
      errors++; $display("FAIL match_next_word: got %0b expected 0", page_offset_match_o);
    end
    drive_push(1'b1, 64'hABCD_0000_0000_0A00, 64'h2, 1'b1);
    page_offset_i = 12'hA00;
    #1;
    checks++;
    if (page_offset_match_o !== 1'b1) begin
      errors++; $display("FAIL match_incoming: got %0b expected 1", page_offset_match_o);
    end
    drive_push(1'b0, 64'hABCD_0000_0000_0A00, 64'h2, 1'b1);
    #1;
    checks++;
    if (page_offset_match_o !== 1'b0) begin
      errors++; $display("FAIL match_not_valid: got %0b expected 0", page_offset_match_o);
    end
    drive_push(1'b1, 64'hABCD_0000_0000_0A00, 64'h2, 1'b1);
    tick();
    drive_push(1'b0, '0, '0, 1'b0);
    mem_gnt_i = 1'b1;
    for (int k = 0; k < 10 && count_o != '0; k++) tick();
    mem_gnt_i = 1'b0;
    page_offset_i = 12'hF10;
    #1;
    checks++;
    if (page_offset_match_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++; $display("FAIL match_drained: match=%0b empty=%0b expected 0/1", page_offset_match_o,
                         empty_o);
    end
    page_offset_i = 12'h000;
    tick();
  endtask

  task automatic test_wrap_random();
    beat_t sent[11];
    beat_t got[$];
    int    idx = 0;
    for (int i = 0; i < 11; i++) begin
      sent[i].addr = {32'h9000_0000, 20'($urandom), 12'($urandom) & 12'hFF8};
      sent[i].data = {$urandom, $urandom};
      sent[i].last = 1'($urandom);
    end
    for (int c = 0; c < 400 && !(idx == 11 && got.size() == 11); c++) begin
      if (idx < 11) drive_push(1'($urandom), sent[idx].addr, sent[idx].data, sent[idx].last);
      else          drive_push(1'b0, '0, '0, 1'b0);
      mem_gnt_i     = 1'($urandom_range(0, 2) != 0);
      page_offset_i = 12'($urandom);
      #1;
      if (push_valid_i && push_ready_o) idx++;
      if (mem_req_o && mem_gnt_i) begin
        automatic beat_t b;
        b.addr = mem_addr_o;
        b.data = mem_wdata_o;
        b.last = 1'b0;
        got.push_back(b);
      end
      @(posedge clk_i);
      #1;
    end
    drive_push(1'b0, '0, '0, 1'b0);
    mem_gnt_i = 1'b0;
    checks++;
    if (got.size() != 11 || idx != 11) begin
      errors++; $display("FAIL wrap_count: pushed %0d drained %0d expected 11/11", idx, got.size());
    end
    for (int i = 0; i < 11 && i < got.size(); i++) begin
      checks++;
      if (got[i].addr !== sent[i].addr || got[i].data !== sent[i].data) begin
        errors++; $display("FAIL wrap_order: beat %0d got %h/%h expected %h/%h", i, got[i].addr,
                           got[i].data, sent[i].addr, sent[i].data);
      end
    end
    tick();
  endtask

  task automatic test_reset_midop();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 64'h7000_0000 + 64'(i * 8), 64'(i + 100), 1'b1);
      tick();
    end
    drive_push(1'b0, '0, '0, 1'b0);
    checks++;
    if (count_o !== CW'(3)) begin
      errors++; $display("FAIL midop_fill: count got %0d expected 3", count_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || count_o !== '0 || mem_be_o !== 8'h00) begin
      errors++; $display("FAIL midop_async: req=%0b count=%0d be=%h expected 0/0/00", mem_req_o,
                         count_o, mem_be_o);
    end
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
    checks++;
    if (count_o !== '0 || empty_o !== 1'b1 || mem_req_o !== 1'b0 || frame_done_o !== 1'b0) begin
      errors++; $display("FAIL midop_release: count=%0d empty=%0b req=%0b fd=%0b", count_o, empty_o,
                         mem_req_o, frame_done_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_simul();
    test_match();
    test_wrap_random();
    test_reset_midop();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
